// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback/long-latency/decode/register-file signal bundle for rf_wb_arbiter
interface rf_wb_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        wb_hold;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic        lu_iss;
    logic [4:0]  lu_iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_en;
    logic        rs2_en;
    logic [4:0]  rd_chk;
    logic        rd_chk_en;
    logic        hz_stall;
    logic        RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;

    modport slave (
        input  wb_we, wb_rd, wb_wd, lu_valid, lu_rd, lu_wd, lu_iss, lu_iss_rd,
        input  rs1, rs2, rs1_en, rs2_en, rd_chk, rd_chk_en,
        output wb_hold, lu_ready, hz_stall, RFWr, A3, WD
    );

    modport master (
        output wb_we, wb_rd, wb_wd, lu_valid, lu_rd, lu_wd, lu_iss, lu_iss_rd,
        output rs1, rs2, rs1_en, rs2_en, rd_chk, rd_chk_en,
        input  wb_hold, lu_ready, hz_stall, RFWr, A3, WD
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter between WB and a long-latency unit, with busy scoreboard
module rf_wb_arbiter #(
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 4
) (
    input logic          clk,
    input logic          rst,
    rf_wb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               hold_q;
    logic [31:0]        busy, busy_nxt, clr_mask, busy_eff;
    logic               wb_act, wb_grant, lu_grant;

    always_comb begin
        wb_act = bus.wb_we && (bus.wb_rd != 5'd0);
        if (state == ST_FORCE) begin
            wb_grant = 1'b0;
            lu_grant = 1'b1;
        end else begin
            wb_grant = wb_act;
            lu_grant = bus.lu_valid && !wb_act;
        end
    end

    always_comb begin
        bus.RFWr = 1'b0;
        bus.A3   = 5'd0;
        bus.WD   = 32'd0;
        if (wb_grant) begin
            bus.RFWr = 1'b1;
            bus.A3   = bus.wb_rd;
            bus.WD   = bus.wb_wd;
        end else if (lu_grant && (bus.lu_rd != 5'd0)) begin
            bus.RFWr = 1'b1;
            bus.A3   = bus.lu_rd;
            bus.WD   = bus.lu_wd;
        end
    end

    assign bus.lu_ready = lu_grant;
    // Registered decode of FORCE so the WB freeze cannot glitch.
    assign bus.wb_hold  = hold_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.lu_valid && wb_act) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!bus.lu_valid || lu_grant) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(STARVE_LIM - 1)) begin
                    state_nxt = ST_FORCE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_FORCE: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Set after clear so a same-cycle reissue of the retiring register stays busy.
    always_comb begin
        clr_mask = lu_grant ? (32'd1 << bus.lu_rd) : 32'd0;
        busy_nxt = busy & ~clr_mask;
        if (bus.lu_iss && (bus.lu_iss_rd != 5'd0)) begin
            busy_nxt[bus.lu_iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        busy_eff     = busy & ~clr_mask;
        bus.hz_stall = (busy_eff[bus.rs1]    && bus.rs1_en) ||
                       (busy_eff[bus.rs2]    && bus.rs2_en) ||
                       (busy_eff[bus.rd_chk] && bus.rd_chk_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hold_q <= 1'b0;
            busy   <= 32'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hold_q <= (state_nxt == ST_FORCE);
            busy   <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    localparam int STARVE_LIM = 4;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIM(STARVE_LIM), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Sample mid-cycle and retire any register-file write against the scoreboard.
    task automatic settle();
        logic [36:0] e;
        @(negedge clk);
        if (bus.RFWr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("rf_unexpected_write", {27'd0, bus.A3}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("rf_a3", {27'd0, bus.A3}, {27'd0, e[36:32]});
                check_val("rf_wd", bus.WD, e[31:0]);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_wd = 0;
        bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_wd = 0;
        bus.lu_iss = 0; bus.lu_iss_rd = 0;
        bus.rs1 = 0; bus.rs2 = 0; bus.rs1_en = 0; bus.rs2_en = 0;
        bus.rd_chk = 0; bus.rd_chk_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_rfwr", {31'd0, bus.RFWr}, 32'd0);
        check_val("rst_a3", {27'd0, bus.A3}, 32'd0);
        check_val("rst_wd", bus.WD, 32'd0);
        check_val("rst_wb_hold", {31'd0, bus.wb_hold}, 32'd0);
        check_val("rst_lu_ready", {31'd0, bus.lu_ready}, 32'd0);
        check_val("rst_hz_stall", {31'd0, bus.hz_stall}, 32'd0);
        adv();
        rst = 1'b0;

        // Issue to x5, then read x5.
        bus.lu_iss = 1; bus.lu_iss_rd = 5; bus.rs1 = 5; bus.rs1_en = 1;
        settle();
        check_val("iss_same_cycle_nostall", {31'd0, bus.hz_stall}, 32'd0);
        adv();
        bus.lu_iss = 0;
        settle();
        check_val("busy5_stall", {31'd0, bus.hz_stall}, 32'd1);
        bus.rs1 = 0;
        #1;
        check_val("x0_nostall", {31'd0, bus.hz_stall}, 32'd0);
        adv();

        // Uncontended LU write to x5 with forwarding mask.
        bus.rs1 = 5; bus.lu_valid = 1; bus.lu_rd = 5; bus.lu_wd = 32'hDEAD_BEEF;
        push_wr(5, 32'hDEAD_BEEF);
        settle();
        check_val("lu_uncontended_ready", {31'd0, bus.lu_ready}, 32'd1);
        check_val("lu_fwd_nostall", {31'd0, bus.hz_stall}, 32'd0);
        adv();
        bus.lu_valid = 0;
        settle();
        check_val("busy5_cleared", {31'd0, bus.hz_stall}, 32'd0);
        check_val("idle_rfwr", {31'd0, bus.RFWr}, 32'd0);
        adv();
        bus.rs1_en = 0;

        // One-cycle contention: WB first, LU next cycle.
        bus.wb_we = 1; bus.wb_rd = 3; bus.wb_wd = 32'h11;
        bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_wd = 32'h77;
        push_wr(3, 32'h11);
        push_wr(7, 32'h77);
        settle();
        check_val("contend_lu_blocked", {31'd0, bus.lu_ready}, 32'd0);
        check_val("contend_no_hold", {31'd0, bus.wb_hold}, 32'd0);
        adv();
        bus.wb_we = 0;
        settle();
        check_val("wait_lu_granted", {31'd0, bus.lu_ready}, 32'd1);
        adv();
        bus.lu_valid = 0;
        settle();
        adv();

        // Starvation: WB held, forced LU grant after STARVE_LIM blocked cycles.
        bus.lu_valid = 1; bus.lu_rd = 10; bus.lu_wd = 32'hCAFE;
        bus.wb_we = 1; bus.wb_rd = 4;
        for (int i = 0; i < STARVE_LIM; i++) begin
            bus.wb_wd = 32'hA0 + i;
            push_wr(4, 32'hA0 + i);
            settle();
            check_val("starve_lu_blocked", {31'd0, bus.lu_ready}, 32'd0);
            check_val("starve_no_hold", {31'd0, bus.wb_hold}, 32'd0);
            adv();
        end
        bus.wb_wd = 32'hB0;
        push_wr(10, 32'hCAFE);
        settle();
        check_val("force_hold", {31'd0, bus.wb_hold}, 32'd1);
        check_val("force_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
        adv();
        bus.lu_valid = 0;
        push_wr(4, 32'hB0);
        settle();
        check_val("after_force_no_hold", {31'd0, bus.wb_hold}, 32'd0);
        adv();
        bus.wb_we = 0;

        // Same-cycle retire and reissue of x9: set wins.
        bus.lu_iss = 1; bus.lu_iss_rd = 9;
        bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_wd = 32'h99;
        push_wr(9, 32'h99);
        settle();
        check_val("x9_ready", {31'd0, bus.lu_ready}, 32'd1);
        adv();
        bus.lu_iss = 0; bus.lu_valid = 0;
        bus.rs2 = 9; bus.rs2_en = 1;
        settle();
        check_val("x9_set_wins", {31'd0, bus.hz_stall}, 32'd1);
        adv();
        bus.lu_valid = 1; bus.lu_wd = 32'h999;
        push_wr(9, 32'h999);
        settle();
        check_val("x9_fwd_mask", {31'd0, bus.hz_stall}, 32'd0);
        adv();
        bus.rs2_en = 0;

        // LU write to x0 completes the handshake without writing.
        bus.lu_rd = 0; bus.lu_wd = 32'h55;
        settle();
        check_val("x0_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
        check_val("x0_lu_no_rfwr", {31'd0, bus.RFWr}, 32'd0);
        adv();
        bus.lu_valid = 0;

        // WB to x0 is not a write and does not block the LU.
        bus.wb_we = 1; bus.wb_rd = 0; bus.wb_wd = 32'h66;
        bus.lu_valid = 1; bus.lu_rd = 8; bus.lu_wd = 32'h88;
        push_wr(8, 32'h88);
        settle();
        check_val("wb_x0_lu_ready", {31'd0, bus.lu_ready}, 32'd1);
        adv();
        idle_inputs();

        // Mark x12 busy, then starve the LU until one step before FORCE.
        bus.lu_iss = 1; bus.lu_iss_rd = 12;
        settle();
        adv();
        bus.lu_iss = 0;
        bus.rd_chk = 12; bus.rd_chk_en = 1;
        settle();
        check_val("waw_stall", {31'd0, bus.hz_stall}, 32'd1);
        adv();
        bus.wb_we = 1; bus.wb_rd = 2;
        bus.lu_valid = 1; bus.lu_rd = 12; bus.lu_wd = 32'h1212;
        for (int i = 0; i < STARVE_LIM - 1; i++) begin
            bus.wb_wd = 32'hC0 + i;
            push_wr(2, 32'hC0 + i);
            settle();
            adv();
        end
        bus.wb_we = 0; bus.lu_valid = 0;
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_hold", {31'd0, bus.wb_hold}, 32'd0);
        check_val("arst_busy_clear", {31'd0, bus.hz_stall}, 32'd0);
        check_val("arst_rfwr", {31'd0, bus.RFWr}, 32'd0);
        adv();
        rst = 1'b0;

        // A surviving WAIT/cnt would force on the first blocked cycle.
        bus.wb_we = 1; bus.wb_wd = 32'hD0;
        bus.lu_valid = 1;
        for (int i = 0; i < 2; i++) begin
            push_wr(2, 32'hD0);
            settle();
            check_val("post_rst_no_force", {31'd0, bus.wb_hold}, 32'd0);
            check_val("post_rst_lu_blocked", {31'd0, bus.lu_ready}, 32'd0);
            adv();
        end
        bus.wb_we = 0;
        push_wr(12, 32'h1212);
        settle();
        check_val("post_rst_lu_granted", {31'd0, bus.lu_ready}, 32'd1);
        adv();
        idle_inputs();
        settle();

        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file (x0 hard-wired zero; same-cycle write data is forwarded to both read ports).
- Shares that port between the in-order pipeline writeback (WB) and one long-latency unit (LU, e.g. mul/div).
- Keeps a busy scoreboard of LU destination registers and raises the decode-stage hazard stall.
- Forces one LU write through when WB has starved the LU for too long.

Parameters:
- STARVE_LIM, 4, number of consecutive blocked LU cycles before a forced grant; legal range 2..15.
- CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_LIM.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_we  in  1  pipeline WB write request.
- wb_rd  in  5  pipeline WB destination register.
- wb_wd  in  32  pipeline WB write data.
- wb_hold  out  1  WB not written this cycle; the pipeline must freeze WB and retry next cycle.
- lu_valid  in  1  LU result valid.
- lu_rd  in  5  LU destination register.
- lu_wd  in  32  LU result data.
- lu_ready  out  1  LU result accepted this cycle.
- lu_iss  in  1  LU operation issued this cycle.
- lu_iss_rd  in  5  destination register of the issued LU operation.
- rs1, rs2  in  5 each  decode-stage source registers.
- rs1_en, rs2_en  in  1 each  the source register is actually read.
- rd_chk  in  5  decode-stage destination register (WAW check).
- rd_chk_en  in  1  the decode-stage instruction writes rd_chk.
- hz_stall  out  1  decode must stall.
- RFWr  out  1  register-file write enable.
- A3  out  5  register-file write address.
- WD  out  32  register-file write data.

Behaviour:
- Reset: state=IDLE, cnt=0, busy=0. Outputs: RFWr=0, A3=0, WD=0, wb_hold=0, lu_ready=0, hz_stall=0. A reset mid-operation drops any pending LU result; the LU must be flushed by the same reset.
- Grant logic is combinational, from inputs, state and cnt.
  - wb_act = wb_we & (wb_rd!=0).
  - In IDLE/WAIT: WB wins when wb_act. The LU is granted (lu_ready=1) when lu_valid & !wb_act.
  - In FORCE: the LU is granted unconditionally and wb_hold=1.
- RF outputs:
  - WB granted: RFWr=1, A3=wb_rd, WD=wb_wd.
  - LU granted with lu_rd!=0: RFWr=1, A3=lu_rd, WD=lu_wd.
  - LU granted with lu_rd==0: handshake completes, RFWr=0.
  - Otherwise: RFWr=0, A3=0, WD=0.
- wb_hold = (state==FORCE). It is a pure state decode, glitch-free, and never asserted outside FORCE.
- FSM states: IDLE, WAIT, FORCE.
  - IDLE: lu_valid & wb_act -> WAIT, cnt=1. Otherwise stay in IDLE.
  - WAIT: lu granted -> IDLE, cnt=0. Still blocked and cnt==STARVE_LIM-1 -> FORCE. Still blocked otherwise -> cnt+1. lu_valid deasserted -> IDLE, cnt=0; LU results must be held until accepted, so this is illegal but defined.
  - FORCE: exactly one cycle, then -> IDLE, cnt=0.
  - Worst-case LU wait is STARVE_LIM+1 cycles from first lu_valid.
- Scoreboard busy[31:0]; bit 0 is always 0.
  - Set: lu_iss & lu_iss_rd!=0 sets busy[lu_iss_rd] at the edge.
  - Clear: a granted LU write clears busy[lu_rd] at the edge.
  - Set and clear of the same register in one cycle: set wins.
- hz_stall is combinational.
  - It is the OR of busy_eff[rs1]&rs1_en, busy_eff[rs2]&rs2_en, and busy_eff[rd_chk]&rd_chk_en.
  - busy_eff = busy with the bit of a same-cycle granted LU write masked off; the RF forwards that write.
  - Register 0 never stalls.
- Issue with lu_iss_rd already busy is prevented by rd_chk stall; the block does not check for it.

Test Plan:
- Reset -> all outputs 0. lu_iss with lu_iss_rd=5, then rs1=5/rs1_en=1 -> hz_stall=1 next cycle; rs1=0 -> hz_stall=0.
- lu_valid, lu_rd=5, lu_wd=0xDEADBEEF, wb_we=0 -> same cycle lu_ready=1, RFWr=1, A3=5, WD=0xDEADBEEF, hz_stall=0 for rs1=5; busy[5]=0 after the edge.
- wb_we=1, wb_rd=3, wb_wd=0x11 together with lu_valid, lu_rd=7 for one cycle, then wb_we=0 -> WB written first (A3=3), LU written next cycle (A3=7); FSM IDLE->WAIT->IDLE.
- wb_we=1 held continuously, lu_valid held, STARVE_LIM=4 -> lu_ready=0 for 4 cycles, FORCE on cycle 5 with wb_hold=1, lu_ready=1, A3=lu_rd. Next cycle WB is written again and wb_hold=0.
- Same cycle: LU write to x9 granted and lu_iss with lu_iss_rd=9 -> busy[9]=1 after the edge. LU write with lu_rd=0 -> lu_ready=1, RFWr=0.
- rst pulsed while in WAIT with busy[12]=1 -> state IDLE, busy=0, wb_hold=0 immediately (asynchronous).
